// File: rtl/slon5_rlookup.sv
// slon5_rlookup
//
// Reverse lookup for the slon5 datapath. Given a target table element, it
// scans a synchronous-read table from address 0 upward and reports the
// lowest index that holds the element. The index is returned raw (rsp_idx)
// and polarity-adjusted (rsp_dnum = polarity ? idx : ~idx), which is the
// same rule the forward path uses.
//
// Handshakes: a transfer happens on any rising clk edge where valid and
// ready are both high. Once valid is raised, the producer holds it and its
// payload stable until that edge. The consumer may drive ready freely.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake; req_value/req_polarity are the payload
//   tbl_rd/tbl_addr table read strobe and address (registered outputs)
//   tbl_data        table read data, valid on the cycle after tbl_rd
//   rsp_valid/ready response handshake; rsp_found/rsp_idx/rsp_dnum are the payload
//   dbg_state       current FSM state (IDLE=0, SCAN=1, RESP=2)

module slon5_rlookup #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_value,
    input  logic              req_polarity,
    output logic              tbl_rd,
    output logic [IDX_W-1:0]  tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [IDX_W-1:0]  rsp_dnum,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] value_q;
    logic              pol_q;

    // Compare stage: describes the read whose data is on tbl_data this cycle.
    logic              cmp_valid;
    logic [IDX_W-1:0]  cmp_addr;
    logic              cmp_last;

    logic accept;
    logic data_eq;
    logic hit;
    logic miss_done;
    logic rd_last;

    always_comb begin
        accept    = (state == IDLE) && req_valid;
        data_eq   = (tbl_data == value_q);
        hit       = (state == SCAN) && cmp_valid && data_eq;
        miss_done = (state == SCAN) && cmp_valid && cmp_last && !data_eq;
        // Termination uses an explicit last-address compare so the counter
        // never has to wrap when DEPTH equals 2**IDX_W.
        rd_last   = (tbl_addr == LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)              state_nxt = SCAN;
            SCAN: if (hit || miss_done)    state_nxt = RESP;
            RESP: if (rsp_ready)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            pol_q     <= 1'b0;
            tbl_rd    <= 1'b0;
            tbl_addr  <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_last  <= 1'b0;
            rsp_found <= 1'b0;
            rsp_idx   <= '0;
            rsp_dnum  <= '0;
        end else begin
            // A read issued this cycle is compared next cycle. A read still
            // in flight when a hit lands is dropped here.
            cmp_valid <= tbl_rd && !hit;
            cmp_addr  <= tbl_addr;
            cmp_last  <= rd_last;

            if (accept) begin
                value_q  <= req_value;
                pol_q    <= req_polarity;
                tbl_rd   <= 1'b1;
                tbl_addr <= '0;
            end else if (state == SCAN) begin
                if (hit) begin
                    tbl_rd    <= 1'b0;
                    rsp_found <= 1'b1;
                    rsp_idx   <= cmp_addr;
                    rsp_dnum  <= pol_q ? cmp_addr : ~cmp_addr;
                end else if (miss_done) begin
                    tbl_rd    <= 1'b0;
                    rsp_found <= 1'b0;
                    rsp_idx   <= '0;
                    rsp_dnum  <= pol_q ? '0 : '1;
                end else if (tbl_rd) begin
                    if (rd_last) begin
                        tbl_rd <= 1'b0;
                    end else begin
                        tbl_addr <= tbl_addr + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule
